// File: rtl/clint_irq.sv
// ----------------------------------------------------------------------------
// clint_irq : core-local interruptor (machine timer + software interrupt)
//
// Holds mtime, mtimecmp and msip behind a small request/ack bus port and turns
// them into a registered interrupt request for the trap handler.
//
// Register map (8-byte aligned, bus_addr[2:0] ignored):
//   0x0000  msip      bit 0 only, other bits read as 0
//   0x4000  mtimecmp
//   0xBFF8  mtime
//   other   reads 0, writes dropped, bus_err flagged with the ack
//
// Ports:
//   clk, rst               core clock, asynchronous active-high reset
//   bus_req/we/addr        access request, direction, byte offset
//   bus_wstrb/wdata        per-byte write enables, write data
//   bus_rdata/ack/err      registered response, ack is a one-cycle pulse
//   priv_lvl, mstatus_mie  global interrupt enable inputs
//   mie_msie, mie_mtie     per-source enables
//   irq_en/code/val        registered interrupt request to the trap handler
//   mip_out                MSIP at bit 3, MTIP at bit 7 (ignores enables)
//   mtime_out              current mtime for time/rdtime
//
// Build option:
//   CLINT_PRESCALER_EN  when defined, mtime advances once every TICK_DIV
//                       clocks through a 16-bit prescaler; otherwise mtime
//                       advances every clock and TICK_DIV is unused.
// ----------------------------------------------------------------------------

// Per-byte write merge for the two 64-bit timer registers. A strobed byte
// takes the bus data; an unstrobed byte keeps the value it would have had
// without the write (the incremented mtime byte, or the old mtimecmp byte).
module clint_byte_lane (
    input  logic [7:0] inc_byte,
    input  logic [7:0] cmp_byte,
    input  logic [7:0] wbyte,
    input  logic       strb,
    input  logic       wr_time,
    input  logic       wr_cmp,
    output logic [7:0] time_nxt,
    output logic [7:0] cmp_nxt
);
    assign time_nxt = (wr_time && strb) ? wbyte : inc_byte;
    assign cmp_nxt  = (wr_cmp  && strb) ? wbyte : cmp_byte;
endmodule

module clint_irq #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [7:0]        bus_wstrb,
    input  logic [63:0]       bus_wdata,
    output logic [63:0]       bus_rdata,
    output logic              bus_ack,
    output logic              bus_err,
    input  logic [1:0]        priv_lvl,
    input  logic              mstatus_mie,
    input  logic              mie_msie,
    input  logic              mie_mtie,
    output logic              irq_en,
    output logic [3:0]        irq_code,
    output logic [63:0]       irq_val,
    output logic [63:0]       mip_out,
    output logic [63:0]       mtime_out
);
    localparam int NB = 8;

    localparam logic [ADDR_W-1:0] OFF_MSIP = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] OFF_CMP  = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] OFF_TIME = ADDR_W'(16'hBFF8);

    localparam logic [3:0] CODE_SW   = 4'd3;
    localparam logic [3:0] CODE_TM   = 4'd7;
    localparam logic [3:0] CODE_NONE = 4'd0;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP,
        REG_TIME
    } reg_sel_e;

    typedef struct packed {
        logic     rd;
        logic     wr;
        reg_sel_e sel;
    } req_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NB-1:0][7:0] mtime;
    logic [NB-1:0][7:0] mtimecmp;
    logic               msip;

    logic [NB-1:0][7:0] mtime_inc;
    logic [NB-1:0][7:0] mtime_nxt;
    logic [NB-1:0][7:0] mtimecmp_nxt;
    logic [NB-1:0][7:0] wdata_b;
    logic               msip_nxt;

    logic               acc;
    logic               tick;
    logic               wr_time;
    logic               wr_cmp;
    logic               wr_msip;
    req_t               req;
    logic [63:0]        rd_mux;

    logic               mtip;
    logic               gie;
    logic               sw_p;
    logic               tm_p;
    logic [3:0]         code_nxt;

    // Offset bits below the 8-byte word are don't-care.
    logic               unused_addr_lsb;
    assign unused_addr_lsb = ^bus_addr[2:0];

    // ------------------------------------------------------------------
    // Bus accept and decode
    // ------------------------------------------------------------------
    // While the ack is on the bus a held request is not taken again, so a
    // continuously asserted bus_req yields one access every two cycles.
    assign acc = bus_req & ~bus_ack;

    always_comb begin
        req     = '0;
        req.rd  = acc & ~bus_we;
        req.wr  = acc &  bus_we;
        req.sel = REG_NONE;
        if (bus_addr[ADDR_W-1:3] == OFF_MSIP[ADDR_W-1:3])
            req.sel = REG_MSIP;
        else if (bus_addr[ADDR_W-1:3] == OFF_CMP[ADDR_W-1:3])
            req.sel = REG_CMP;
        else if (bus_addr[ADDR_W-1:3] == OFF_TIME[ADDR_W-1:3])
            req.sel = REG_TIME;
    end

    assign wr_time = req.wr && (req.sel == REG_TIME);
    assign wr_cmp  = req.wr && (req.sel == REG_CMP);
    assign wr_msip = req.wr && (req.sel == REG_MSIP);

    // Reads observe the registers before this edge's increment.
    always_comb begin
        rd_mux = '0;
        case (req.sel)
            REG_MSIP: rd_mux = {63'b0, msip};
            REG_CMP:  rd_mux = mtimecmp;
            REG_TIME: rd_mux = mtime;
            default:  rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
`ifdef CLINT_PRESCALER_EN
    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0] presc;

    // Tick on the wrap of the prescaler; an mtime write restarts the phase
    // so software sees a full TICK_DIV period after writing the counter.
    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (wr_time || tick)
            presc <= '0;
        else
            presc <= presc + 16'd1;
    end
`else
    assign tick = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state for the timer registers
    // ------------------------------------------------------------------
    assign mtime_inc = mtime + 64'(tick);
    assign wdata_b   = bus_wdata;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        clint_byte_lane u_lane (
            .inc_byte (mtime_inc[k]),
            .cmp_byte (mtimecmp[k]),
            .wbyte    (wdata_b[k]),
            .strb     (bus_wstrb[k]),
            .wr_time  (wr_time),
            .wr_cmp   (wr_cmp),
            .time_nxt (mtime_nxt[k]),
            .cmp_nxt  (mtimecmp_nxt[k])
        );
    end

    assign msip_nxt = (wr_msip && bus_wstrb[0]) ? bus_wdata[0] : msip;

    // ------------------------------------------------------------------
    // Interrupt sources and selection
    // ------------------------------------------------------------------
    assign mtip = (mtime >= mtimecmp);
    assign gie  = (priv_lvl != 2'b11) | mstatus_mie;
    assign sw_p = msip & mie_msie;
    assign tm_p = mtip & mie_mtie;

    // Software interrupt wins over the timer.
    always_comb begin
        code_nxt = CODE_NONE;
        if (sw_p)
            code_nxt = CODE_SW;
        else if (tm_p)
            code_nxt = CODE_TM;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            msip      <= 1'b0;
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
            irq_en    <= 1'b0;
            irq_code  <= CODE_NONE;
        end else begin
            mtime     <= mtime_nxt;
            mtimecmp  <= mtimecmp_nxt;
            msip      <= msip_nxt;
            bus_ack   <= acc;
            bus_err   <= acc && (req.sel == REG_NONE);
            bus_rdata <= req.rd ? rd_mux : '0;
            // Level-sensitive: follows the sources with one cycle of delay.
            irq_en    <= gie & (sw_p | tm_p);
            irq_code  <= code_nxt;
        end
    end

    assign irq_val   = '0;
    assign mip_out   = {56'b0, mtip, 3'b0, msip, 3'b0};
    assign mtime_out = mtime;

endmodule

// File: doc/clint_irq.md
Name: clint_irq

Overview:
- Core-local interruptor holding the machine timer (mtime, mtimecmp) and the software-interrupt register (msip).
- Accessed over a simple memory-mapped request/ack port decoded off the dmem address path.
- Sits directly upstream of the trap handler. Drives its irq_en/irq_code/irq_val inputs, which are currently tied to zero.
- Also exports mip bits for the CSR file and mtime for time/rdtime.

Parameters:
- TICK_DIV, 1, clocks per mtime increment (only honoured with CLINT_PRESCALER_EN); legal range 1..65535.
- ADDR_W, 16, width of the bus offset address.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- bus_req  in  1  access request
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  ADDR_W  byte offset inside the CLINT window; bits [2:0] ignored
- bus_wstrb  in  8  byte enables, same encoding as dmem_word_sel
- bus_wdata  in  64  write data
- bus_rdata  out  64  read data, valid with bus_ack
- bus_ack  out  1  one-cycle response pulse
- bus_err  out  1  unmapped-offset flag, valid with bus_ack
- priv_lvl  in  2  current privilege level
- mstatus_mie  in  1  mstatus bit 3
- mie_msie  in  1  mie bit 3
- mie_mtie  in  1  mie bit 7
- irq_en  out  1  interrupt request to the trap handler
- irq_code  out  4  interrupt cause code
- irq_val  out  64  interrupt tval; always 0
- mip_out  out  64  mip image: bit 3 = MSIP, bit 7 = MTIP, all other bits 0
- mtime_out  out  64  current mtime

Behaviour:
- Register map (8-byte aligned):
  - 0x0000 msip: bit 0 only; other bits read 0.
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
  - Any other offset: read returns 0, write is ignored, bus_err=1 with the ack.
- Reset values: mtime=0, mtimecmp=all ones, msip=0, prescaler=0, bus_ack=0, bus_err=0, bus_rdata=0, irq_en=0, irq_code=0, irq_val=0.
- Handshake:
  - A request is accepted on any cycle with bus_req=1 and no ack pending.
  - bus_ack pulses exactly 1 cycle later, with rdata/err registered.
  - A request held high through its ack is a new request on the cycle after the ack. This gives a maximum of one access per 2 cycles.
  - Writes take effect at the accept edge. A read returns the value before any same-cycle increment.
- Byte strobes: each set bit k updates byte k only. A write with bus_wstrb=0 still acks, with no change.
- Counter:
  - mtime increments by 1 per tick and wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A bus write to mtime in the same cycle as a tick: the written bytes take the written value; unwritten bytes take the incremented value's bytes.
- MTIP = (mtime >= mtimecmp), unsigned compare on current registered values; combinational into the irq logic. MSIP = msip[0].
- Global enable = (priv_lvl != 2'b11) | mstatus_mie.
- Pending:
  - sw_p = MSIP & mie_msie
  - tm_p = MTIP & mie_mtie
- Priority: software over timer.
  - If sw_p: code 3.
  - Else if tm_p: code 7.
- Output registers: irq_en <= enable & (sw_p | tm_p) and irq_code <= selected code (0 when none), both registered. Latency is 1 cycle from a cause change to irq_en.
- Interrupts are level-sensitive with no internal latch. irq_en drops 1 cycle after the source clears: mtimecmp raised, msip cleared, or an enable dropped.
- mip_out is combinational from MSIP/MTIP and is independent of enables.
- Reset asserted mid-access: any pending ack is cancelled and all state returns to reset values.

Optional Feature:
- Macro: CLINT_PRESCALER_EN.
- Defined: a 16-bit prescaler counts 0..TICK_DIV-1; a tick occurs when it wraps. A bus write to mtime clears the prescaler.
- Not defined: a tick occurs every clock, no prescaler flop exists, and TICK_DIV is ignored.

Test Plan:
- Reset, then read 0xBFF8 after 10 cycles -> bus_ack 1 cycle after req; rdata equals the sampled mtime (~10); mtimecmp reads 0xFFFF_FFFF_FFFF_FFFF; irq_en=0.
- Write mtimecmp=0x20, mie_mtie=1, mstatus_mie=1, priv=3 -> irq_en=1, irq_code=7 one cycle after mtime reaches 0x20; write mtimecmp=0x1000 -> irq_en=0 the next cycle.
- Write msip=1 while the timer is also pending -> irq_code=3; clear msip -> irq_code=7; with priv=3 and mstatus_mie=0, irq_en=0 but mip_out=0x88.
- Write mtime=0xFFFF_FFFF_FFFF_FFFE with wstrb=0xFF -> after 2 ticks mtime=0; with mtimecmp=5, MTIP drops on wrap.
- Write 0x1234 with wstrb=0x01 to mtimecmp=all ones -> reads 0xFFFF_FFFF_FFFF_FF34; write to offset 0x0100 -> bus_err=1, no state change.
- With CLINT_PRESCALER_EN and TICK_DIV=4 -> mtime advances by 1 per 4 clocks; an mtime write clears the prescaler phase. Assert rst with a pending ack -> bus_ack stays 0.
